// File: rtl/demux_1xn_buf_if.sv
// -----------------------------------------------------------------------------
// demux_1xn_buf_if
//   Bundle of all producer/consumer signals of the buffered 1-to-N demux.
//
//   Producer side : i, s, bcast, i_valid -> block ; i_ready <- block
//   Consumer side : y, y_valid, occ <- block ; y_ready -> block
//
//   modport slave  : the demux itself
//   modport master : the environment (producer plus the N consumers)
//
//   Channel k data sits on y[k*WIDTH +: WIDTH]; N = 2**SEL_W.
// -----------------------------------------------------------------------------
interface demux_1xn_buf_if #(
   parameter int WIDTH = 8,
   parameter int SEL_W = 2
);
   localparam int N = 2 ** SEL_W;

   logic [WIDTH-1:0]   i;
   logic [SEL_W-1:0]   s;
   logic               bcast;
   logic               i_valid;
   logic               i_ready;
   logic [N*WIDTH-1:0] y;
   logic [N-1:0]       y_valid;
   logic [N-1:0]       y_ready;
   logic [SEL_W:0]     occ;

   modport slave (
      input  i, s, bcast, i_valid, y_ready,
      output i_ready, y, y_valid, occ
   );

   modport master (
      output i, s, bcast, i_valid, y_ready,
      input  i_ready, y, y_valid, occ
   );
endinterface

// File: rtl/demux_1xn_buf.sv
// -----------------------------------------------------------------------------
// demux_1xn_buf
//   Registered 1-to-N demultiplexer. One input word is routed to channel s, or
//   to every channel when bcast=1. Each channel owns a one-entry holding
//   register with its own valid/ready handshake, so consumers stall
//   independently. Broadcast is all-or-nothing: the word is taken only when
//   every channel can take it on the same edge.
//
//   Ports:
//     clk  - rising-edge clock
//     rst  - asynchronous active-high reset, clears all held words
//     bus  - demux_1xn_buf_if.slave
//              i/s/bcast/i_valid/i_ready : producer handshake
//              y/y_valid/y_ready         : N consumer handshakes
//              occ                       : count of channels holding a word
// -----------------------------------------------------------------------------
module demux_1xn_buf #(
   parameter int WIDTH = 8,
   parameter int SEL_W = 2
) (
   input  logic             clk,
   input  logic             rst,
   demux_1xn_buf_if.slave   bus
);
   localparam int N = 2 ** SEL_W;

   logic [N-1:0]            mask;
   logic [N-1:0]            free;
   logic [N-1:0]            load;
   logic [N-1:0]            valid_q;
   logic [N-1:0]            valid_d;
   logic [N-1:0][WIDTH-1:0] data_q;
   logic [SEL_W:0]          occ_q;
   logic [SEL_W:0]          occ_d;
   logic                    ready;
   logic                    accept;

   // Channels addressed by the presented word.
   always_comb begin
      // NOTE: default every always_comb output first so no path leaves it
      // unassigned; otherwise a latch is inferred.
      mask = '0;
      if (bus.bcast) begin
         mask = '1;
      end else begin
         mask[bus.s] = 1'b1;
      end
   end

   // A channel can take a word if it is empty or is being drained this edge.
   assign free   = ~valid_q | bus.y_ready;
   // Ready only when every targeted channel is free; independent of i_valid
   // so the producer may look at it before committing.
   assign ready  = &(free | ~mask);
   assign accept = bus.i_valid & ready;
   assign load   = {N{accept}} & mask;

   // Pop clears the flag unless the same edge reloads the channel.
   assign valid_d = (valid_q & ~bus.y_ready) | load;

   // occ is registered from the next-state valids so it never lags y_valid.
   always_comb begin
      occ_d = '0;
      for (int k = 0; k < N; k++) begin
         occ_d = occ_d + (SEL_W+1)'(valid_d[k]);
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         valid_q <= '0;
         occ_q   <= '0;
         // NOTE: the data registers are reset too because y must read as zero
         // after reset; plain storage that is only read when valid would not
         // need it.
         data_q  <= '0;
      end else begin
         // NOTE: non-blocking assignments for all clocked state so every
         // register samples pre-edge values regardless of statement order.
         valid_q <= valid_d;
         occ_q   <= occ_d;
         for (int k = 0; k < N; k++) begin
            if (load[k]) begin
               data_q[k] <= bus.i;
            end
         end
      end
   end

   assign bus.i_ready = ready;
   assign bus.y       = data_q;
   assign bus.y_valid = valid_q;
   assign bus.occ     = occ_q;

endmodule

// File: tb/tb_demux_1xn_buf.sv
// -----------------------------------------------------------------------------
// tb_demux_1xn_buf
//   Self-checking bench for demux_1xn_buf (WIDTH=8, SEL_W=2). A per-channel
//   array model (held word + full flag) predicts i_ready, y, y_valid and occ.
//   Directed steps cover reset/idle, routing with stalls, blocked broadcast,
//   streaming, drain and asynchronous reset; a random phase follows.
// -----------------------------------------------------------------------------
module tb_demux_1xn_buf;
   localparam int WIDTH = 8;
   localparam int SEL_W = 2;
   localparam int N     = 2 ** SEL_W;

   logic clk = 1'b0;
   logic rst = 1'b0;

   demux_1xn_buf_if #(.WIDTH(WIDTH), .SEL_W(SEL_W)) bus ();

   demux_1xn_buf #(.WIDTH(WIDTH), .SEL_W(SEL_W)) dut (
      .clk (clk),
      .rst (rst),
      .bus (bus)
   );

   always #5 clk = ~clk;

   int checks = 0;
   int errors = 0;

   // Reference model: what each consumer should currently be offered.
   logic [WIDTH-1:0] m_y [N];
   bit               m_v [N];

   task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   task automatic model_reset();
      for (int k = 0; k < N; k++) begin
         m_y[k] = '0;
         m_v[k] = 1'b0;
      end
   endtask

   // A word may enter only if no targeted consumer is full and stalling.
   function automatic bit model_ready(input int sel, input bit bc, input logic [N-1:0] yr);
      for (int k = 0; k < N; k++) begin
         if ((bc || k == sel) && m_v[k] && !yr[k]) return 1'b0;
      end
      return 1'b1;
   endfunction

   task automatic check_outputs(input string tag);
      logic [N-1:0] ev;
      int           cnt;
      ev  = '0;
      cnt = 0;
      for (int k = 0; k < N; k++) begin
         ev[k] = m_v[k];
         cnt  += int'(m_v[k]);
         check($sformatf("%s.y%0d", tag, k), 64'(bus.y[k*WIDTH +: WIDTH]), 64'(m_y[k]));
      end
      check({tag, ".y_valid"}, 64'(bus.y_valid), 64'(ev));
      check({tag, ".occ"}, 64'(bus.occ), 64'(cnt));
   endtask

   // One clock cycle: entered and left 1 time unit after a rising edge.
   task automatic cycle(input string tag, input logic [WIDTH-1:0] d, input int sel,
                        input bit bc, input bit iv, input logic [N-1:0] yr);
      bit rdy;
      bus.i       = d;
      bus.s       = SEL_W'(sel);
      bus.bcast   = bc;
      bus.i_valid = iv;
      bus.y_ready = yr;
      #1;
      rdy = model_ready(sel, bc, yr);
      check({tag, ".i_ready"}, 64'(bus.i_ready), 64'(rdy));
      @(posedge clk);
      for (int k = 0; k < N; k++) begin
         if (iv && rdy && (bc || k == sel)) begin
            m_y[k] = d;
            m_v[k] = 1'b1;
         end else if (m_v[k] && yr[k]) begin
            m_v[k] = 1'b0;
         end
      end
      #1;
      check_outputs(tag);
   endtask

   initial begin
      bus.i       = '0;
      bus.s       = '0;
      bus.bcast   = 1'b0;
      bus.i_valid = 1'b0;
      bus.y_ready = '0;
      model_reset();

      // Reset then idle.
      #1 rst = 1'b1;
      #1;
      check_outputs("reset");
      for (int sv = 0; sv < N; sv++) begin
         for (int b = 0; b < 2; b++) begin
            bus.s     = SEL_W'(sv);
            bus.bcast = b[0];
            #1;
            check($sformatf("idle.i_ready.s%0d.b%0d", sv, b), 64'(bus.i_ready), 64'(1));
         end
      end
      bus.bcast = 1'b0;
      @(negedge clk);
      rst = 1'b0;
      @(posedge clk);
      #1;

      // Single route into a stalled consumer.
      cycle("route", 8'hA5, 2, 1'b0, 1'b1, 4'b0000);
      check("route.y2", 64'(bus.y[2*WIDTH +: WIDTH]), 64'(8'hA5));
      check("route.occ1", 64'(bus.occ), 64'(1));
      cycle("route_blk", 8'h11, 2, 1'b0, 1'b1, 4'b0000);
      check("route_blk.y2", 64'(bus.y[2*WIDTH +: WIDTH]), 64'(8'hA5));
      cycle("route_s1", 8'h22, 1, 1'b0, 1'b1, 4'b0000);
      check("route_s1.valid", 64'(bus.y_valid), 64'(4'b0110));

      // Broadcast blocked by one stalled channel, then released.
      cycle("clear", 8'h00, 0, 1'b0, 1'b0, 4'b1111);
      cycle("load3", 8'h77, 3, 1'b0, 1'b1, 4'b0000);
      cycle("bc_blk", 8'h3C, 0, 1'b1, 1'b1, 4'b0000);
      check("bc_blk.valid", 64'(bus.y_valid), 64'(4'b1000));
      cycle("bc_go", 8'h3C, 0, 1'b1, 1'b1, 4'b1000);
      check("bc_go.valid", 64'(bus.y_valid), 64'(4'b1111));
      check("bc_go.occ", 64'(bus.occ), 64'(4));
      check("bc_go.y", 64'(bus.y), 64'(32'h3C3C3C3C));

      // Streaming into channel 0 at one word per cycle.
      cycle("clear2", 8'h00, 0, 1'b0, 1'b0, 4'b1111);
      for (int w = 1; w <= 4; w++) begin
         cycle($sformatf("stream%0d", w), WIDTH'(w), 0, 1'b0, 1'b1, 4'b0001);
         check($sformatf("stream%0d.y0", w), 64'(bus.y[WIDTH-1:0]), 64'(w));
         check($sformatf("stream%0d.occ", w), 64'(bus.occ), 64'(1));
      end

      // Drain channels 0 and 3 with a single ready pulse.
      cycle("clear3", 8'h00, 0, 1'b0, 1'b0, 4'b1111);
      cycle("ld0", 8'h11, 0, 1'b0, 1'b1, 4'b0000);
      cycle("ld3", 8'h33, 3, 1'b0, 1'b1, 4'b0000);
      cycle("drain", 8'h00, 0, 1'b0, 1'b0, 4'b1001);
      check("drain.valid", 64'(bus.y_valid), 64'(0));
      check("drain.y3", 64'(bus.y[3*WIDTH +: WIDTH]), 64'(8'h33));

      // Asynchronous reset between clock edges.
      cycle("pre1", 8'h5A, 1, 1'b0, 1'b1, 4'b0000);
      cycle("pre2", 8'h6B, 2, 1'b0, 1'b1, 4'b0000);
      check("pre.valid", 64'(bus.y_valid), 64'(4'b0110));
      bus.i_valid = 1'b0;
      #2 rst = 1'b1;
      #1;
      model_reset();
      check_outputs("async_rst");
      @(negedge clk);
      rst = 1'b0;
      @(posedge clk);
      #1;
      cycle("post_rst", 8'hC3, 1, 1'b0, 1'b1, 4'b0000);

      // Random traffic.
      for (int n = 0; n < 400; n++) begin
         cycle("rand", WIDTH'($urandom), int'($urandom_range(0, N-1)),
               ($urandom_range(0, 7) == 0), ($urandom_range(0, 3) != 0),
               N'($urandom));
      end

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end
endmodule
